// File: rtl/led_ctrl_if.sv
// led_ctrl_if: register-map control bits in, LED pin drive out.
// Latency: not applicable (wiring only).
// Backpressure: none; every signal is a level sampled each cycle.
//
// Ports (master = register map / bench, slave = led_ctrl):
//   led_on, led_blink_ena, led_pwm_ena : per-LED enables
//   pwm_duty                           : shared PWM duty
//   prescale, blink_half               : tick period and blink half-period config
//   cnt_clr, lamp_test                 : counter clear pulse, all-on override
//   led, blink_phase                   : registered outputs from led_ctrl
interface led_ctrl_if #(
    parameter int PRESC_W = 16
) ();
    logic [7:0]         led_on;
    logic [7:0]         led_blink_ena;
    logic [7:0]         led_pwm_ena;
    logic [7:0]         pwm_duty;
    logic [PRESC_W-1:0] prescale;
    logic [PRESC_W-1:0] blink_half;
    logic               cnt_clr;
    logic               lamp_test;
    logic [7:0]         led;
    logic               blink_phase;

    modport master (
        output led_on, led_blink_ena, led_pwm_ena, pwm_duty,
               prescale, blink_half, cnt_clr, lamp_test,
        input  led, blink_phase
    );

    modport slave (
        input  led_on, led_blink_ena, led_pwm_ena, pwm_duty,
               prescale, blink_half, cnt_clr, lamp_test,
        output led, blink_phase
    );
endinterface

// File: rtl/led_ctrl.sv
// led_ctrl: drives eight user LEDs (static / blink / PWM / blink+PWM, lamp test).
// Latency: led is registered, 1 clk after any input or counter change.
// Backpressure: none; config is sampled live every cycle, no shadowing.
//
// Ports:
//   clk   : system clock
//   res_n : asynchronous active-low reset
//   bus   : led_ctrl_if.slave carrying config inputs and led/blink_phase outputs
module led_ctrl #(
    parameter int PRESC_W = 16
) (
    input  logic       clk,
    input  logic       res_n,
    led_ctrl_if.slave  bus
);

    localparam logic [PRESC_W-1:0] P_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] r_presc_cnt;
    logic [7:0]         r_pwm_cnt;
    logic [PRESC_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [7:0]         r_led;

    logic               w_tick;
    logic               w_pwm_out;
    logic               w_blink_end;
    logic [7:0]         w_led_c;

    // ">=" rather than "==": if prescale is lowered below the running count
    // the next cycle ticks immediately instead of running the counter to wrap.
    assign w_tick      = ~bus.cnt_clr & (r_presc_cnt >= bus.prescale);
    assign w_pwm_out   = (r_pwm_cnt < bus.pwm_duty);
    assign w_blink_end = (r_blink_cnt >= bus.blink_half);

    // A disabled blink or PWM gate passes 1, so each mode can be combined.
    assign w_led_c = {8{bus.lamp_test}} |
                     (bus.led_on &
                      (~bus.led_blink_ena | {8{r_blink_phase}}) &
                      (~bus.led_pwm_ena   | {8{w_pwm_out}}));

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_presc_cnt   <= '0;
            r_pwm_cnt     <= 8'd0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
            r_led         <= 8'h00;
        end else begin
            r_led <= w_led_c;
            // Clear outranks any tick or toggle falling in the same cycle.
            if (bus.cnt_clr) begin
                r_presc_cnt   <= '0;
                r_pwm_cnt     <= 8'd0;
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b1;
            end else begin
                if (w_tick) begin
                    r_presc_cnt <= '0;
                    r_pwm_cnt   <= r_pwm_cnt + 8'd1;
                    if (w_blink_end) begin
                        r_blink_cnt   <= '0;
                        r_blink_phase <= ~r_blink_phase;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + P_ONE;
                    end
                end else begin
                    r_presc_cnt <= r_presc_cnt + P_ONE;
                end
            end
        end
    end

    assign bus.led         = r_led;
    assign bus.blink_phase = r_blink_phase;

endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: directed bench for led_ctrl.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_led_ctrl;

    logic clk;
    logic res_n;
    int   checks;
    int   errors;

    led_ctrl_if #(.PRESC_W(16)) bus ();

    led_ctrl #(.PRESC_W(16)) u_dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_step();
        bus.cnt_clr = 1'b1;
        step();
        bus.cnt_clr = 1'b0;
    endtask

    initial begin
        logic        s[256];
        int          highs;
        int          changes;
        int          bad;
        int          first_low;
        logic        exp_bit;
        logic [7:0]  duty_tab[3];
        int          high_tab[3];
        int          chg_tab[3];

        checks = 0;
        errors = 0;
        duty_tab = '{8'd64, 8'd0, 8'd255};
        high_tab = '{64, 0, 255};
        chg_tab  = '{2, 0, 2};

        res_n             = 1'b0;
        bus.led_on        = 8'h00;
        bus.led_blink_ena = 8'h00;
        bus.led_pwm_ena   = 8'h00;
        bus.pwm_duty      = 8'h00;
        bus.prescale      = 16'd2;
        bus.blink_half    = 16'd0;
        bus.cnt_clr       = 1'b0;
        bus.lamp_test     = 1'b0;

        repeat (3) step();
        chk("rst_led", bus.led, 8'h00);
        chk("rst_phase", bus.blink_phase, 1'b1);

        // First tick after release with prescale=2 lands 3 cycles later.
        res_n = 1'b1;
        step();
        step();
        chk("first_tick_pre", bus.blink_phase, 1'b1);
        step();
        chk("first_tick", bus.blink_phase, 1'b0);

        // Static on.
        bus.led_on = 8'hA5;
        chk("static_before", bus.led, 8'h00);
        step();
        chk("static_a5", bus.led, 8'hA5);

        // PWM only on LED 0, prescale 0: 256-cycle period.
        bus.prescale    = 16'd0;
        bus.led_on      = 8'h01;
        bus.led_pwm_ena = 8'h01;
        for (int d = 0; d < 3; d++) begin
            bus.pwm_duty = duty_tab[d];
            step();
            step();
            for (int i = 0; i < 256; i++) begin
                step();
                s[i] = bus.led[0];
            end
            highs   = 0;
            changes = 0;
            for (int i = 0; i < 256; i++) begin
                if (s[i]) highs++;
                if (s[i] != s[(i + 1) % 256]) changes++;
            end
            chk("pwm_highs", highs, high_tab[d]);
            chk("pwm_runs", changes, chg_tab[d]);
        end

        // Blink only on LED 3: prescale 3, blink_half 4 -> 20 on / 20 off.
        bus.led_on        = 8'h08;
        bus.led_blink_ena = 8'h08;
        bus.led_pwm_ena   = 8'h00;
        bus.prescale      = 16'd3;
        bus.blink_half    = 16'd4;
        clr_step();
        bad       = 0;
        first_low = 0;
        for (int j = 1; j <= 60; j++) begin
            step();
            exp_bit = (j <= 20) || (j > 40);
            if (bus.led[3] !== exp_bit) bad++;
            if (first_low == 0 && bus.led[3] === 1'b0) first_low = j;
        end
        chk("blink_pattern", bad, 0);
        chk("blink_first_low", first_low, 21);

        // Blink + PWM on LED 7: prescale 0, blink_half 511, duty 128.
        bus.led_on        = 8'h80;
        bus.led_blink_ena = 8'h80;
        bus.led_pwm_ena   = 8'h80;
        bus.prescale      = 16'd0;
        bus.blink_half    = 16'd511;
        bus.pwm_duty      = 8'd128;
        clr_step();
        bad   = 0;
        highs = 0;
        for (int j = 1; j <= 1536; j++) begin
            step();
            exp_bit = (((j - 1) / 512) % 2 == 0) && (((j - 1) % 256) < 128);
            if (bus.led[7] !== exp_bit) bad++;
            if (bus.led[7] === 1'b1) highs++;
        end
        chk("combo_pattern", bad, 0);
        chk("combo_highs", highs, 512);

        // Lower prescale below the running count: immediate tick, then 11-cycle period.
        bus.led_on        = 8'h00;
        bus.led_blink_ena = 8'h00;
        bus.led_pwm_ena   = 8'h00;
        bus.prescale      = 16'd200;
        bus.blink_half    = 16'd0;
        clr_step();
        repeat (100) step();
        chk("presc_hold", bus.blink_phase, 1'b1);
        bus.prescale = 16'd10;
        step();
        chk("presc_force_tick", bus.blink_phase, 1'b0);
        repeat (10) step();
        chk("presc_period_pre", bus.blink_phase, 1'b0);
        step();
        chk("presc_period", bus.blink_phase, 1'b1);
        repeat (10) step();
        // Now in a terminal tick cycle: clear must win over the toggle.
        clr_step();
        chk("clr_wins", bus.blink_phase, 1'b1);
        repeat (10) step();
        chk("clr_restart_pre", bus.blink_phase, 1'b1);
        step();
        chk("clr_restart", bus.blink_phase, 1'b0);

        // Lamp test with counters running underneath.
        bus.prescale   = 16'd0;
        bus.blink_half = 16'd3;
        clr_step();
        step();
        bus.lamp_test = 1'b1;
        step();
        chk("lamp_ff", bus.led, 8'hFF);
        step();
        step();
        chk("lamp_counters", bus.blink_phase, 1'b0);
        step();
        bus.lamp_test     = 1'b0;
        bus.led_on        = 8'hFF;
        bus.led_blink_ena = 8'hFF;
        step();
        chk("lamp_off_mode", bus.led, 8'h00);
        repeat (3) step();
        chk("lamp_off_cont", bus.led, 8'hFF);

        // Asynchronous reset mid-operation.
        res_n = 1'b0;
        #1;
        chk("async_rst_led", bus.led, 8'h00);
        chk("async_rst_phase", bus.blink_phase, 1'b1);
        step();
        res_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
